// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the arbiter's request, result and hazard-query signals.
//   master : drives writeback, issue, MDU result and query inputs
//   slave  : the arbiter; returns mdu_ready, busy flags, pipe_stall and
//            the register-file write port (reg_write, wt_addr, wt_data)
interface regfile_write_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        pipe_stall;
  logic        reg_write;
  logic [4:0]  wt_addr;
  logic [31:0] wt_data;

  modport master (
    output wb_valid, wb_rd, wb_data, iss_valid, iss_rd,
           mdu_valid, mdu_rd, mdu_data, rs1_addr, rs2_addr,
    input  mdu_ready, rs1_busy, rs2_busy, pipe_stall,
           reg_write, wt_addr, wt_data
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, iss_valid, iss_rd,
           mdu_valid, mdu_rd, mdu_data, rs1_addr, rs2_addr,
    output mdu_ready, rs1_busy, rs2_busy, pipe_stall,
           reg_write, wt_addr, wt_data
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares one register-file write port between pipeline writeback and an
// MDU result FIFO. Writeback has priority; a starved FIFO forces a one-cycle
// pipe_stall so its head can write. A 31-bit scoreboard tracks registers
// with pending MDU writes for hazard queries.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : regfile_write_arbiter_if.slave (writeback, MDU issue and
//                result handshake, rs1/rs2 busy queries, write port)
module regfile_write_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_write_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       mem_rd   [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_cnt;
  logic [STV_W-1:0] starve_nxt;
  logic             pipe_stall_q;
  logic             stall_nxt;
  logic [31:1]      sb;
  logic [31:1]      set_mask;
  logic [31:1]      clr_mask;
  logic [31:0]      sb_full;

  logic             fifo_empty;
  logic             ready_c;
  logic             push;
  logic             grant;
  logic             wb_sel;
  logic [4:0]       head_rd;
  logic [31:0]      head_data;
  logic             reg_write_c;
  logic [4:0]       wt_addr_c;
  logic [31:0]      wt_data_c;

  // FIFO status and arbitration decision
  assign fifo_empty = (count == '0);
  assign ready_c    = (count < CNT_W'(DEPTH));
  assign push       = bus.mdu_valid && ready_c;
  assign grant      = !fifo_empty && (!bus.wb_valid || pipe_stall_q);
  assign wb_sel     = bus.wb_valid && !pipe_stall_q;
  assign head_rd    = mem_rd[rd_ptr];
  assign head_data  = mem_data[rd_ptr];

  // Write port: FIFO head when granted, else unstalled writeback, else idle
  always_comb begin
    reg_write_c = 1'b0;
    wt_addr_c   = '0;
    wt_data_c   = '0;
    if (rst_n) begin
      if (grant) begin
        wt_addr_c   = head_rd;
        wt_data_c   = head_data;
        reg_write_c = (head_rd != 5'd0);
      end else if (wb_sel) begin
        wt_addr_c   = bus.wb_rd;
        wt_data_c   = bus.wb_data;
        reg_write_c = (bus.wb_rd != 5'd0);
      end
    end
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= bus.mdu_rd;
      mem_data[wr_ptr] <= bus.mdu_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (grant) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, grant})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Scoreboard masks; x0 is never tracked, and a set overrides a clear
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 1; i < 32; i++) begin
      set_mask[i] = bus.iss_valid && (bus.iss_rd == 5'(i));
      clr_mask[i] = grant && (head_rd == 5'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb <= '0;
    else        sb <= (sb & ~clr_mask) | set_mask;
  end

  // Bit 0 of the widened view is constant 0, so address 0 is never busy
  assign sb_full = {sb, 1'b0};

  // Starvation counter: counts blocked cycles of a non-empty FIFO
  always_comb begin
    starve_nxt = '0;
    if (!fifo_empty && !grant) begin
      starve_nxt = (starve_cnt < STV_W'(STARVE_LIMIT)) ? starve_cnt + STV_W'(1)
                                                       : starve_cnt;
    end
    stall_nxt = (starve_nxt == STV_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt   <= '0;
      pipe_stall_q <= 1'b0;
    end else begin
      starve_cnt   <= starve_nxt;
      pipe_stall_q <= stall_nxt;
    end
  end

  assign bus.mdu_ready  = ready_c;
  assign bus.rs1_busy   = sb_full[bus.rs1_addr];
  assign bus.rs2_busy   = sb_full[bus.rs2_addr];
  assign bus.pipe_stall = pipe_stall_q;
  assign bus.reg_write  = reg_write_c;
  assign bus.wt_addr    = wt_addr_c;
  assign bus.wt_data    = wt_data_c;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_regfile_write_arbiter;

  localparam int unsigned DEPTH        = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic clk;
  logic rst_n;

  regfile_write_arbiter_if bus_if();

  regfile_write_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Behavioural model state
  ent_t     q[$];
  bit [31:0] sb;
  int       blocked;
  bit       m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, then advance the model
  always @(negedge clk) begin : cmp
    int          n;
    bit          g;
    bit          w;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    ent_t        e;
    if (!rst_n) begin
      q.delete();
      sb      = '0;
      blocked = 0;
      m_stall = 0;
      chk("m_rst_ready", 32'(bus_if.mdu_ready), 32'd1);
      chk("m_rst_we",    32'(bus_if.reg_write), 32'd0);
      chk("m_rst_addr",  32'(bus_if.wt_addr),   32'd0);
      chk("m_rst_data",  bus_if.wt_data,        32'd0);
      chk("m_rst_busy1", 32'(bus_if.rs1_busy),  32'd0);
      chk("m_rst_busy2", 32'(bus_if.rs2_busy),  32'd0);
      chk("m_rst_stall", 32'(bus_if.pipe_stall), 32'd0);
    end else begin
      n = q.size();
      g = (n > 0) && (!bus_if.wb_valid || m_stall);
      w = !g && bus_if.wb_valid && !m_stall;
      e_we = 1'b0; e_addr = '0; e_data = '0;
      if (g) begin
        e_addr = q[0].rd; e_data = q[0].data; e_we = (q[0].rd != 0);
      end else if (w) begin
        e_addr = bus_if.wb_rd; e_data = bus_if.wb_data; e_we = (bus_if.wb_rd != 0);
      end
      chk("m_ready", 32'(bus_if.mdu_ready), 32'(n < DEPTH));
      chk("m_stall", 32'(bus_if.pipe_stall), 32'(m_stall));
      chk("m_we",    32'(bus_if.reg_write), 32'(e_we));
      chk("m_addr",  32'(bus_if.wt_addr),   32'(e_addr));
      chk("m_data",  bus_if.wt_data,        e_data);
      chk("m_busy1", 32'(bus_if.rs1_busy), 32'((bus_if.rs1_addr != 0) && sb[bus_if.rs1_addr]));
      chk("m_busy2", 32'(bus_if.rs2_busy), 32'((bus_if.rs2_addr != 0) && sb[bus_if.rs2_addr]));
      // State advance at the coming rising edge
      if (g) begin
        e = q.pop_front();
        sb[e.rd] = 1'b0;
      end
      if (bus_if.iss_valid && bus_if.iss_rd != 0) sb[bus_if.iss_rd] = 1'b1;
      if (bus_if.mdu_valid && n < DEPTH) q.push_back('{bus_if.mdu_rd, bus_if.mdu_data});
      if (n > 0 && !g) blocked++;
      else             blocked = 0;
      m_stall = (blocked == STARVE_LIMIT);
    end
  end

  task automatic idle();
    bus_if.wb_valid  = 1'b0; bus_if.wb_rd  = '0; bus_if.wb_data  = '0;
    bus_if.iss_valid = 1'b0; bus_if.iss_rd = '0;
    bus_if.mdu_valid = 1'b0; bus_if.mdu_rd = '0; bus_if.mdu_data = '0;
    bus_if.rs1_addr  = '0;   bus_if.rs2_addr = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  function automatic logic [4:0] rnd_rd();
    return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    chk("reset_ready", 32'(bus_if.mdu_ready), 32'd1);
    chk("reset_we",    32'(bus_if.reg_write), 32'd0);
    chk("reset_busy",  32'(bus_if.rs1_busy),  32'd0);
    cyc(); rst_n = 1'b1;

    // Issue x5, MDU result, write one cycle after accept, busy clears
    cyc(); bus_if.iss_valid = 1; bus_if.iss_rd = 5; bus_if.rs1_addr = 5;
    settle(); chk("a_busy_pre", 32'(bus_if.rs1_busy), 32'd0);
    cyc(); bus_if.iss_valid = 0; bus_if.mdu_valid = 1; bus_if.mdu_rd = 5; bus_if.mdu_data = 32'hDEADBEEF;
    settle();
    chk("a_busy_acc", 32'(bus_if.rs1_busy), 32'd1);
    chk("a_ready",    32'(bus_if.mdu_ready), 32'd1);
    chk("a_nobypass", 32'(bus_if.reg_write), 32'd0);
    cyc(); bus_if.mdu_valid = 0;
    settle();
    chk("a_we",   32'(bus_if.reg_write), 32'd1);
    chk("a_addr", 32'(bus_if.wt_addr),   32'd5);
    chk("a_data", bus_if.wt_data,        32'hDEADBEEF);
    chk("a_busy_wr", 32'(bus_if.rs1_busy), 32'd1);
    cyc(); settle();
    chk("a_busy_post", 32'(bus_if.rs1_busy), 32'd0);
    chk("a_we_post",   32'(bus_if.reg_write), 32'd0);

    // Starvation: WB x3 held, one queued MDU entry
    cyc(); bus_if.wb_valid = 1; bus_if.wb_rd = 3; bus_if.wb_data = 32'h33;
    bus_if.mdu_valid = 1; bus_if.mdu_rd = 10; bus_if.mdu_data = 32'hAAAA;
    settle(); chk("b_wb0", 32'(bus_if.wt_addr), 32'd3);
    for (int i = 1; i <= 4; i++) begin
      cyc(); bus_if.mdu_valid = 0;
      settle();
      chk("b_nostall", 32'(bus_if.pipe_stall), 32'd0);
      chk("b_wb_addr", 32'(bus_if.wt_addr),    32'd3);
      chk("b_wb_we",   32'(bus_if.reg_write),  32'd1);
    end
    cyc(); settle();
    chk("b_stall",      32'(bus_if.pipe_stall), 32'd1);
    chk("b_stall_addr", 32'(bus_if.wt_addr),    32'd10);
    chk("b_stall_data", bus_if.wt_data,         32'hAAAA);
    cyc(); settle();
    chk("b_resume_stall", 32'(bus_if.pipe_stall), 32'd0);
    chk("b_resume_addr",  32'(bus_if.wt_addr),    32'd3);

    // Two back-to-back results fill the FIFO; order kept
    cyc(); bus_if.mdu_valid = 1; bus_if.mdu_rd = 7; bus_if.mdu_data = 32'h7;
    settle(); chk("c_ready1", 32'(bus_if.mdu_ready), 32'd1);
    cyc(); bus_if.mdu_rd = 8; bus_if.mdu_data = 32'h8;
    settle(); chk("c_ready2", 32'(bus_if.mdu_ready), 32'd1);
    cyc(); bus_if.mdu_rd = 9; bus_if.mdu_data = 32'h9;
    settle(); chk("c_ready3", 32'(bus_if.mdu_ready), 32'd0);
    cyc(); bus_if.mdu_valid = 0; bus_if.wb_valid = 0;
    settle();
    chk("c_first_addr", 32'(bus_if.wt_addr), 32'd7);
    chk("c_first_data", bus_if.wt_data,      32'h7);
    cyc(); settle(); chk("c_second_addr", 32'(bus_if.wt_addr), 32'd8);
    cyc(); settle();
    chk("c_idle_we",   32'(bus_if.reg_write), 32'd0);
    chk("c_idle_addr", 32'(bus_if.wt_addr),   32'd0);
    chk("c_idle_data", bus_if.wt_data,        32'd0);

    // Issue and pop of x9 together keep bit 9; rd=0 result pops without write
    cyc(); bus_if.iss_valid = 1; bus_if.iss_rd = 9; bus_if.rs1_addr = 9;
    cyc(); bus_if.iss_valid = 0; bus_if.mdu_valid = 1; bus_if.mdu_rd = 9; bus_if.mdu_data = 32'h99;
    cyc(); bus_if.mdu_valid = 0; bus_if.iss_valid = 1;
    settle(); chk("d_pop_addr", 32'(bus_if.wt_addr), 32'd9);
    cyc(); bus_if.iss_valid = 0;
    settle(); chk("d_setwins", 32'(bus_if.rs1_busy), 32'd1);
    cyc(); bus_if.mdu_valid = 1; bus_if.mdu_rd = 0; bus_if.mdu_data = 32'h1234;
    cyc(); bus_if.mdu_valid = 0;
    settle();
    chk("d_rd0_we",   32'(bus_if.reg_write), 32'd0);
    chk("d_rd0_addr", 32'(bus_if.wt_addr),   32'd0);

    // Reset with two queued entries and bits 4,6 set
    cyc(); bus_if.wb_valid = 1; bus_if.wb_rd = 2; bus_if.wb_data = 32'h22;
    bus_if.iss_valid = 1; bus_if.iss_rd = 4; bus_if.rs1_addr = 4; bus_if.rs2_addr = 6;
    cyc(); bus_if.iss_rd = 6; bus_if.mdu_valid = 1; bus_if.mdu_rd = 4; bus_if.mdu_data = 32'h44;
    cyc(); bus_if.iss_valid = 0; bus_if.mdu_rd = 6; bus_if.mdu_data = 32'h66;
    cyc(); bus_if.mdu_valid = 0;
    settle();
    chk("e_full",  32'(bus_if.mdu_ready), 32'd0);
    chk("e_busy4", 32'(bus_if.rs1_busy),  32'd1);
    chk("e_busy6", 32'(bus_if.rs2_busy),  32'd1);
    cyc(); rst_n = 1'b0;
    #1;
    chk("e_rst_busy4", 32'(bus_if.rs1_busy),  32'd0);
    chk("e_rst_busy6", 32'(bus_if.rs2_busy),  32'd0);
    chk("e_rst_ready", 32'(bus_if.mdu_ready), 32'd1);
    chk("e_rst_we",    32'(bus_if.reg_write), 32'd0);
    chk("e_rst_addr",  32'(bus_if.wt_addr),   32'd0);
    cyc(); rst_n = 1'b1; bus_if.wb_valid = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(); settle();
      chk("e_nowrite", 32'(bus_if.reg_write), 32'd0);
    end

    // WB to x0 with empty FIFO never writes
    cyc(); bus_if.wb_valid = 1; bus_if.wb_rd = 0; bus_if.wb_data = 32'h55;
    settle(); chk("f_wb_x0", 32'(bus_if.reg_write), 32'd0);
    cyc(); bus_if.wb_rd = 12;
    settle();
    chk("f_wb_we",   32'(bus_if.reg_write), 32'd1);
    chk("f_wb_addr", 32'(bus_if.wt_addr),   32'd12);

    // Randomized traffic, occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst_n            = ($urandom_range(0, 399) != 0);
      bus_if.wb_valid  = ($urandom_range(0, 9) < 6);
      bus_if.wb_rd     = rnd_rd();
      bus_if.wb_data   = $urandom;
      bus_if.iss_valid = ($urandom_range(0, 9) < 3);
      bus_if.iss_rd    = rnd_rd();
      bus_if.mdu_valid = ($urandom_range(0, 9) < 4);
      bus_if.mdu_rd    = rnd_rd();
      bus_if.mdu_data  = $urandom;
      bus_if.rs1_addr  = rnd_rd();
      bus_if.rs2_addr  = rnd_rd();
    end
    cyc(); rst_n = 1'b1; idle();
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
